// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: rebuilds active-pixel coordinates from hs/vs/blank,
// measures line/frame timing against the nominal parameters, and reports lock plus sticky errors.
module vga_sync_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       hs,
  input  logic       vs,
  input  logic       blank,
  input  logic       clr_err,
  output logic       rx_de,
  output logic [9:0] rx_x,
  output logic [9:0] rx_y,
  output logic       frame_start,
  output logic       locked,
  output logic [4:0] err_flags
);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] TRACK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3ff) ? v : v + 10'd1;
  endfunction

  logic       hs_q, vs_q;
  logic [9:0] h_cnt, hs_lo, act_cnt, v_cnt, vs_lo, act_lines, good;
  logic       h_seen, v_seen, frame_err;
  logic [1:0] state, state_nxt;
  logic [9:0] good_nxt, good_inc;
  logic       hs_fall, hs_rise, vs_fall, vs_rise;
  logic [4:0] err_ev;
  logic       any_err, close_err;

  assign hs_fall = hs_q & ~hs;
  assign hs_rise = ~hs_q & hs;
  assign vs_fall = vs_q & ~vs;
  assign vs_rise = ~vs_q & vs;

  // Every check is gated by a seen-flag so the partial period after reset is never judged.
  assign err_ev[0] = hs_fall & h_seen & (h_cnt != 10'(H_TOTAL - 1));
  assign err_ev[1] = hs_rise & h_seen & (hs_lo != 10'(H_SYNC));
  assign err_ev[2] = hs_fall & h_seen & (act_cnt != 10'd0) & (act_cnt != 10'(H_ACTIVE));
  assign err_ev[3] = vs_fall & v_seen & (v_cnt != 10'(V_TOTAL - 1));
  assign err_ev[4] = vs_rise & v_seen & (vs_lo != 10'(V_SYNC));
  assign any_err   = |err_ev;
  // An error landing on the vs fall itself belongs to the frame being closed.
  assign close_err = frame_err | any_err;
  assign good_inc  = sat_inc(good);

  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    case (state)
      SEARCH: if (vs_fall) begin
        state_nxt = TRACK;
        good_nxt  = 10'd0;
      end
      TRACK: if (vs_fall) begin
        good_nxt = close_err ? 10'd0 : good_inc;
        if (!close_err && (good_inc >= 10'(LOCK_FRAMES))) state_nxt = LOCKED;
      end
      LOCKED: if (any_err) begin
        state_nxt = TRACK;
        good_nxt  = 10'd0;
      end
      default: begin
        state_nxt = SEARCH;
        good_nxt  = 10'd0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      h_cnt       <= '0;
      hs_lo       <= '0;
      act_cnt     <= '0;
      v_cnt       <= '0;
      vs_lo       <= '0;
      act_lines   <= '0;
      good        <= '0;
      h_seen      <= 1'b0;
      v_seen      <= 1'b0;
      frame_err   <= 1'b0;
      state       <= SEARCH;
      rx_de       <= 1'b0;
      rx_x        <= '0;
      rx_y        <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err_flags   <= '0;
    end else begin
      hs_q <= hs;
      vs_q <= vs;

      h_cnt <= hs_fall ? 10'd0 : sat_inc(h_cnt);
      if (hs_fall) h_seen <= 1'b1;
      // The falling sample is itself the first low cycle of the pulse.
      if (hs_fall)  hs_lo <= 10'd1;
      else if (!hs) hs_lo <= sat_inc(hs_lo);
      if (hs_fall)     act_cnt <= 10'd0;
      else if (blank)  act_cnt <= sat_inc(act_cnt);

      if (vs_fall)      v_cnt <= 10'd0;
      else if (hs_fall) v_cnt <= sat_inc(v_cnt);
      if (vs_fall) begin
        v_seen <= 1'b1;
        vs_lo  <= {9'd0, hs_fall};
      end else if (!vs && hs_fall) begin
        vs_lo  <= sat_inc(vs_lo);
      end
      if (vs_fall)                           act_lines <= 10'd0;
      else if (hs_fall && act_cnt != 10'd0)  act_lines <= sat_inc(act_lines);

      rx_de <= blank;
      if (blank) begin
        rx_x <= act_cnt;
        rx_y <= act_lines;
      end
      frame_start <= vs_fall;

      err_flags <= (clr_err ? 5'd0 : err_flags) | err_ev;
      frame_err <= vs_fall ? 1'b0 : (frame_err | any_err);
      state     <= state_nxt;
      good      <= good_nxt;
      locked    <= (state_nxt == LOCKED);
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor on a scaled-down raster: directed frame table, mid-frame reset,
// then randomly faulted frames checked against a frame-level lock/error model.
module tb_vga_sync_monitor;

  localparam int HT = 40, HS = 6, HA = 24, A0 = 10;
  localparam int VT = 20, VS = 2, VA0 = 3, VA = 12, LK = 2, BADL = 5;

  logic       Clk = 1'b0, Reset = 1'b1;
  logic       hs = 1'b1, vs = 1'b1, blank = 1'b0, clr_err = 1'b0;
  logic       rx_de, frame_start, locked;
  logic [9:0] rx_x, rx_y;
  logic [4:0] err_flags;

  vga_sync_monitor #(.H_TOTAL(HT), .H_SYNC(HS), .H_ACTIVE(HA), .V_TOTAL(VT),
                     .V_SYNC(VS), .LOCK_FRAMES(LK)) dut (
    .Clk(Clk), .Reset(Reset), .hs(hs), .vs(vs), .blank(blank), .clr_err(clr_err),
    .rx_de(rx_de), .rx_x(rx_x), .rx_y(rx_y), .frame_start(frame_start),
    .locked(locked), .err_flags(err_flags));

  always #5 Clk = ~Clk;

  int n_checks = 0, n_fail = 0, stream_bad = 0;
  // expected registered stream outputs (one sample behind the inputs)
  logic       exp_de = 1'b0, exp_fs = 1'b0;
  logic [9:0] exp_x = '0, exp_y = '0;
  int         act_lines_done = 0;
  // frame-level model
  int         r = 0;
  bit         in_frame = 0, prev_bad = 0, exp_lk = 0;
  logic [4:0] exp_err = '0, pend = '0;

  // kinds: 0 clean, 1 long line, 2 short hsync, 3 short active, 4 long vsync, 5 extra line
  typedef struct {int kind; bit clr; logic [4:0] err; bit lk;} vec_t;
  vec_t tbl[17];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input bit h, input bit v, input bit b, input int x, input int y,
                      input bit vf, input bit clr);
    @(negedge Clk);
    if (rx_de !== exp_de || rx_x !== exp_x || rx_y !== exp_y || frame_start !== exp_fs)
      stream_bad++;
    hs = h; vs = v; blank = b; clr_err = clr;
    exp_de = b;
    exp_fs = vf;
    if (b) begin
      exp_x = 10'(x);
      exp_y = 10'(y);
    end
  endtask

  task automatic line(input int len, input int sync, input int act, input bit vl,
                      input bit clr, input bit vf, input int from, input int to);
    for (int p = from; p < to; p++)
      tick(p >= sync, vl, (act > 0) && (p >= A0) && (p < A0 + act), p - A0,
           act_lines_done, vf && (p == 0), clr && (p == from));
    if (to == len && act > 0) act_lines_done++;
  endtask

  function automatic logic [4:0] mid_bits(input int kind);
    case (kind)
      1: return 5'b00001;
      2: return 5'b00010;
      3: return 5'b00100;
      4: return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  // Lock = LK consecutive clean closed frames; any mid-frame error drops it.
  task automatic model_start(input int kind, input bit clr);
    if (clr) exp_err = '0;
    exp_err |= pend;
    if (in_frame) r = prev_bad ? 0 : r + 1;
    in_frame = 1;
    exp_err |= mid_bits(kind);
    exp_lk = (r >= LK) && (mid_bits(kind) == 5'b0);
    prev_bad = (kind != 0);
    pend = (kind == 5) ? 5'b01000 : 5'b00000;
    act_lines_done = 0;
  endtask

  task automatic frame_line(input int kind, input int l, input bit clr, input int vsl,
                            input int from, input int to);
    int len, sync, act;
    len  = HT + ((kind == 1 && l == BADL) ? 1 : 0);
    sync = (kind == 2 && l == BADL) ? HS - 1 : HS;
    act  = (l >= VA0 && l < VA0 + VA) ? ((kind == 3 && l == BADL) ? HA - 1 : HA) : 0;
    line(len, sync, act, l >= vsl, clr && l == 0, l == 0, from, (to < 0) ? len : to);
  endtask

  task automatic run_frame(input int kind, input bit clr);
    model_start(kind, clr);
    for (int l = 0; l < ((kind == 5) ? VT + 1 : VT); l++)
      frame_line(kind, l, clr, (kind == 4) ? 3 : VS, 0, -1);
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b1;
    clr_err = 1'b0;
    @(negedge Clk);
    chk("rst rx_de", rx_de, 0);
    chk("rst rx_x", rx_x, 0);
    chk("rst rx_y", rx_y, 0);
    chk("rst frame_start", frame_start, 0);
    chk("rst locked", locked, 0);
    chk("rst err_flags", err_flags, 0);
    Reset = 1'b0;
    exp_de = 0; exp_fs = 0; exp_x = '0; exp_y = '0;
    act_lines_done = 0; r = 0; in_frame = 0; prev_bad = 0; exp_err = '0; pend = '0;
    stream_bad = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 1'b0, 5'b00000, 1'b0};
    tbl[1]  = '{0, 1'b0, 5'b00000, 1'b0};
    tbl[2]  = '{0, 1'b0, 5'b00000, 1'b1};
    tbl[3]  = '{1, 1'b0, 5'b00001, 1'b0};
    tbl[4]  = '{0, 1'b1, 5'b00000, 1'b0};
    tbl[5]  = '{0, 1'b0, 5'b00000, 1'b0};
    tbl[6]  = '{0, 1'b0, 5'b00000, 1'b1};
    tbl[7]  = '{2, 1'b0, 5'b00010, 1'b0};
    tbl[8]  = '{4, 1'b1, 5'b10000, 1'b0};
    tbl[9]  = '{5, 1'b1, 5'b00000, 1'b0};
    tbl[10] = '{0, 1'b0, 5'b01000, 1'b0};
    tbl[11] = '{0, 1'b1, 5'b00000, 1'b0};
    tbl[12] = '{0, 1'b0, 5'b00000, 1'b1};
    tbl[13] = '{3, 1'b0, 5'b00100, 1'b0};
    tbl[14] = '{0, 1'b1, 5'b00000, 1'b0};
    tbl[15] = '{0, 1'b0, 5'b00000, 1'b0};
    tbl[16] = '{0, 1'b0, 5'b00000, 1'b1};

    apply_reset();

    for (int i = 0; i < 17; i++) begin
      run_frame(tbl[i].kind, tbl[i].clr);
      chk($sformatf("tbl%0d locked", i), locked, tbl[i].lk);
      chk($sformatf("tbl%0d err_flags", i), err_flags, tbl[i].err);
      chk($sformatf("tbl%0d stream", i), stream_bad, 0);
      stream_bad = 0;
    end

    // Partial frame up to the back porch of an active line, then reset.
    model_start(0, 1'b0);
    for (int l = 0; l < 8; l++) frame_line(0, l, 1'b0, VS, 0, -1);
    frame_line(0, 8, 1'b0, VS, 0, 8);
    chk("pre-reset locked", locked, 1);
    chk("pre-reset rx_y", rx_y, 4);
    chk("pre-reset stream", stream_bad, 0);
    apply_reset();
    for (int l = 8; l < VT; l++) frame_line(0, l, 1'b0, VS, (l == 8) ? 8 : 0, -1);
    chk("post-reset err_flags", err_flags, 0);
    chk("post-reset locked", locked, 0);
    chk("post-reset stream", stream_bad, 0);
    stream_bad = 0;

    for (int i = 0; i < 14; i++) begin
      int  k;
      bit  c;
      k = int'($urandom_range(0, 9));
      if (k > 5) k = 0;
      c = bit'($urandom_range(0, 1));
      run_frame(k, c);
      chk($sformatf("rnd%0d k%0d locked", i, k), locked, exp_lk);
      chk($sformatf("rnd%0d k%0d err_flags", i, k), err_flags, exp_err);
      chk($sformatf("rnd%0d stream", i), stream_bad, 0);
      stream_bad = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of vga_controller: samples hs/vs/blank, one sample per pixel clock.
- Rebuilds active-pixel coordinates and measures line/frame timing against 640x480 parameters.
- Reports lock and sticky timing-error flags.
- Sits beside vga_controller, or at any downstream tap, as on-chip video check and coordinate recovery for capture/overlay logic.

Parameters:
H_TOTAL, 800, pixel clocks per line (hs fall to hs fall)
H_SYNC, 96, hs low width in pixel clocks
H_ACTIVE, 640, active (blank=1) pixels per line
V_TOTAL, 525, lines per frame (vs fall to vs fall)
V_SYNC, 2, hs falls counted while vs low
LOCK_FRAMES, 2, consecutive clean frames required for lock

Ports:
Clk  in  1  pixel clock (25 MHz VGA_Clk); one video sample per rising edge
Reset  in  1  synchronous, active-high
hs  in  1  horizontal sync, active low
vs  in  1  vertical sync, active low
blank  in  1  active low blanking (1 = displayed pixel)
clr_err  in  1  one-cycle pulse, clears sticky error flags
rx_de  out  1  registered blank, 1-cycle latency
rx_x  out  10  active pixel index of pixel flagged by rx_de
rx_y  out  10  active line index of pixel flagged by rx_de
frame_start  out  1  one-cycle pulse, cycle after vs fall sampled
locked  out  1  timing locked
err_flags  out  5  sticky {v_width, v_period, h_active, h_width, h_period}

Behaviour:
- Clock and reset: single clock Clk. Reset synchronous, active-high.
- Reset state: all outputs 0. State SEARCH, all counters 0, seen-flags 0. hs_q/vs_q preload to 1, so no false edge on the first sample.
- Edge detect: fall = prev 1 & cur 0; rise = prev 0 & cur 1; prev held in hs_q/vs_q.
- Counter width: all counters 10-bit, saturate at 1023. A saturated value never equals a parameter, so it always flags a mismatch.

Horizontal:
- h_cnt clears to 0 on hs fall, else +1.
- On hs fall with h_seen=1: if old h_cnt != H_TOTAL-1, set h_period. Then set h_seen.
- hs_lo counts cycles with hs=0, clears on hs fall. On hs rise: if count != H_SYNC, set h_width.
- act_cnt counts blank=1 cycles in the line, clears on hs fall. On hs fall: if act_cnt != 0 and != H_ACTIVE, set h_active.

Vertical:
- v_cnt +1 per hs fall; clears on vs fall.
- On vs fall with v_seen=1: if old v_cnt != V_TOTAL-1, set v_period.
- vs_lo counts hs falls while vs=0. On vs rise: if count != V_SYNC, set v_width.

Coordinates (registered, 1-cycle latency):
- rx_de = blank delayed one cycle.
- rx_x = act_cnt value at sample time: 0 for the first active pixel of a line, 639 for the last.
- rx_y = count of completed lines with act_cnt != 0 since last vs fall; 0..479.
- When rx_de=0, rx_x/rx_y hold their last values.

Errors:
- Error set and clr_err in the same cycle: set wins.
- A frame_err internal flag is set by any error event and cleared at each vs fall.

FSM:
- SEARCH: on vs fall, go to TRACK with good=0.
- TRACK: on vs fall, if frame_err=0 then good+1, else good=0. When good reaches LOCK_FRAMES, go to LOCKED.
- LOCKED: any error event returns to TRACK with good=0. locked drops on the cycle after the event.
- locked = (state==LOCKED), registered.
- Simultaneous error and vs fall: the error is counted against the closing frame.
- Reset mid-frame: immediate return to the reset state. The first partial period after reset is never compared.

Test Plan:
- Nominal 640x480 stream, 4 frames -> frame_start pulses every 420000 cycles; locked=1 cycle after 3rd vs fall; err_flags=0.
- Nominal stream: rx_x 0..639 and rx_y 0..479 with rx_de, each 1 cycle after blank=1; rx_x=639, rx_y=479 on the last pixel.
- One line of 801 clocks, after lock -> h_period set, locked=0 next cycle; relocks after 2 further clean frames; clr_err -> err_flags=0.
- hs low 95 clocks on one line -> h_width set only; v-flags unchanged.
- vs low for 3 lines; a separate frame with 526 lines -> v_width, then v_period set; good counter restarts.
- Reset asserted mid-line at line 200 -> next cycle all outputs 0, state SEARCH; first post-reset periods raise no error.
